// File: rtl/osc_bank_if.sv
// Bus bundle for the oscillator bank: sample tick, config writes and tagged sample stream.
interface osc_bank_if #(
  parameter int CHANNELS = 4,
  parameter int BITDEPTH = 12,
  parameter int INCW     = 19
);
  localparam int CW = $clog2(CHANNELS);

  logic                sample_tick;
  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [INCW-1:0]     wr_inc;
  logic [1:0]          wr_wave;
  logic [BITDEPTH-1:0] wr_pw;
  logic [BITDEPTH-1:0] sample_out;
  logic [CW-1:0]       sample_chan;
  logic                sample_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output sample_tick, wr_en, wr_chan, wr_inc, wr_wave, wr_pw,
    input  sample_out, sample_chan, sample_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, wr_en, wr_chan, wr_inc, wr_wave, wr_pw,
    output sample_out, sample_chan, sample_valid, busy, overrun
  );
endinterface

// File: rtl/osc_bank.sv
// Time-multiplexed phase-accumulator oscillator bank. One shared adder and
// waveform generator walk through all channels, one per clock, after each tick.
module osc_bank #(
  parameter int CHANNELS    = 4,
  parameter int BITDEPTH    = 12,
  parameter int BITFRACTION = 12,
  parameter int INCW        = 19
) (
  input  logic      clk,
  input  logic      rst_n,
  osc_bank_if.slave bus
);
  localparam int ACCW = BITDEPTH + BITFRACTION;
  localparam int CW   = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [BITDEPTH-1:0] PW_RESET = {1'b1, {(BITDEPTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] ch_reg, ch_next;
  logic          run;

  // Per-channel register read ports, gathered for the shared datapath mux.
  logic [ACCW-1:0]     phase_rd [CHANNELS];
  logic [INCW-1:0]     inc_rd   [CHANNELS];
  logic [1:0]          wave_rd  [CHANNELS];
  logic [BITDEPTH-1:0] pw_rd    [CHANNELS];
  logic [15:0]         lfsr_rd  [CHANNELS];

  // Shared datapath signals for the channel being processed this cycle.
  logic [ACCW-1:0]     cur_phase, new_phase;
  logic [INCW-1:0]     cur_inc;
  logic [1:0]          cur_wave;
  logic [BITDEPTH-1:0] cur_pw;
  logic [15:0]         cur_lfsr, lfsr_new;
  logic [ACCW:0]       sum;
  logic                carry;
  logic [BITDEPTH-1:0] p, tri_t, wave_val;

  logic [BITDEPTH-1:0] sample_out_reg;
  logic [CW-1:0]       sample_chan_reg;
  logic                sample_valid_reg;
  logic                overrun_reg;

  assign run = (state_reg == RUN);

  // Per-channel state: phase/lfsr advance only when this channel is processed,
  // config registers only on a matching write. Reads see pre-edge values, so a
  // write to the channel under processing takes effect from the next tick.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : chan_g
    localparam logic [CW-1:0] IDX = CW'(gi);
    logic [ACCW-1:0]     phase_reg;
    logic [INCW-1:0]     inc_reg;
    logic [1:0]          wave_reg;
    logic [BITDEPTH-1:0] pw_reg;
    logic [15:0]         lfsr_reg;

    // Channel state update
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        phase_reg <= '0;
        inc_reg   <= '0;
        wave_reg  <= 2'd0;
        pw_reg    <= PW_RESET;
        lfsr_reg  <= 16'hACE1;
      end else begin
        if (run && ch_reg == IDX) begin
          phase_reg <= new_phase;
          lfsr_reg  <= lfsr_new;
        end
        if (bus.wr_en && bus.wr_chan == IDX) begin
          inc_reg  <= bus.wr_inc;
          wave_reg <= bus.wr_wave;
          pw_reg   <= bus.wr_pw;
        end
      end
    end

    assign phase_rd[gi] = phase_reg;
    assign inc_rd[gi]   = inc_reg;
    assign wave_rd[gi]  = wave_reg;
    assign pw_rd[gi]    = pw_reg;
    assign lfsr_rd[gi]  = lfsr_reg;
  end

  // Shared accumulator, LFSR step and waveform generator
  always_comb begin
    cur_phase = phase_rd[ch_reg];
    cur_inc   = inc_rd[ch_reg];
    cur_wave  = wave_rd[ch_reg];
    cur_pw    = pw_rd[ch_reg];
    cur_lfsr  = lfsr_rd[ch_reg];
    sum       = {1'b0, cur_phase} + {{(ACCW + 1 - INCW){1'b0}}, cur_inc};
    new_phase = sum[ACCW-1:0];
    carry     = sum[ACCW];
    // Noise only advances when the phase wraps, so inc=0 freezes it.
    lfsr_new  = carry ? {cur_lfsr[14:0], cur_lfsr[15] ^ cur_lfsr[13] ^ cur_lfsr[12] ^ cur_lfsr[10]}
                      : cur_lfsr;
    p         = new_phase[ACCW-1:BITFRACTION];
    tri_t     = {p[BITDEPTH-2:0], 1'b0};
    case (cur_wave)
      2'd0:    wave_val = p;
      2'd1:    wave_val = (p < cur_pw) ? {BITDEPTH{1'b1}} : '0;
      2'd2:    wave_val = p[BITDEPTH-1] ? ~tri_t : tri_t;
      default: wave_val = lfsr_new[15 -: BITDEPTH];
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  // Sequencer next state: ticks outside IDLE are ignored (flagged below)
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: begin
        if (bus.sample_tick) begin
          state_next = RUN;
          ch_next    = '0;
        end
      end
      RUN: begin
        if (ch_reg == LAST_CH) begin
          state_next = IDLE;
          ch_next    = '0;
        end else begin
          ch_next = ch_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        ch_next    = '0;
      end
    endcase
  end

  // Output sample register and sticky overrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out_reg   <= '0;
      sample_chan_reg  <= '0;
      sample_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      sample_valid_reg <= run;
      if (run) begin
        sample_out_reg  <= wave_val;
        sample_chan_reg <= ch_reg;
      end
      if (run && bus.sample_tick) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.sample_out   = sample_out_reg;
  assign bus.sample_chan  = sample_chan_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.busy         = run;
  assign bus.overrun      = overrun_reg;
endmodule
